// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: sequences loads/stores onto the mmu chipSel/write/ready
// port, stalls upstream while an access is outstanding, and registers the WB record.
module mem_stage_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic        ex_load,
   input  logic        ex_store,
   input  logic        ex_wb_en,
   input  logic [4:0]  ex_rd,
   input  logic [7:0]  ex_addr,
   input  logic [31:0] ex_wdata,
   input  logic [31:0] ex_alu,
   output logic        stall,
   output logic        mmu_sel,
   output logic [7:0]  mmu_addr,
   output logic        mmu_write,
   inout  logic [31:0] mmu_dat,
   input  logic        mmu_ready,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data
);

   typedef enum logic [2:0] {
      SETTLE,
      IDLE,
      WR,
      RD_ISSUE,
      RD_WAIT,
      DRAIN
   } state_t;

   state_t      state, stateNext;
   logic [1:0]  settleCnt, settleCntNext;
   logic [31:0] storeData, storeDataNext;
   logic [4:0]  loadRd, loadRdNext;
   logic        loadWbEn, loadWbEnNext;
   logic        selNext, writeNext;
   logic [7:0]  addrNext;
   logic        wbValidNext;
   logic [4:0]  wbRdNext;
   logic [31:0] wbDataNext;
   logic        isLoad, isStore;

   // Load wins when both kind bits are set.
   assign isLoad  = ex_load;
   assign isStore = ex_store & ~ex_load;

   assign stall   = (state != IDLE);
   assign mmu_dat = (mmu_sel & mmu_write) ? storeData : 'z;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SETTLE;
         settleCnt <= '0;
         storeData <= '0;
         loadRd    <= '0;
         loadWbEn  <= 1'b0;
         mmu_sel   <= 1'b0;
         mmu_write <= 1'b0;
         mmu_addr  <= '0;
         wb_valid  <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
      end else begin
         state     <= stateNext;
         settleCnt <= settleCntNext;
         storeData <= storeDataNext;
         loadRd    <= loadRdNext;
         loadWbEn  <= loadWbEnNext;
         mmu_sel   <= selNext;
         mmu_write <= writeNext;
         mmu_addr  <= addrNext;
         wb_valid  <= wbValidNext;
         wb_rd     <= wbRdNext;
         wb_data   <= wbDataNext;
      end
   end

   always_comb begin
      stateNext     = state;
      settleCntNext = settleCnt;
      storeDataNext = storeData;
      loadRdNext    = loadRd;
      loadWbEnNext  = loadWbEn;
      selNext       = mmu_sel;
      writeNext     = mmu_write;
      addrNext      = mmu_addr;
      wbValidNext   = 1'b0;
      wbRdNext      = wb_rd;
      wbDataNext    = wb_data;

      unique case (state)
         SETTLE: begin
            // Lets any mmu read left over from before reset finish unobserved.
            selNext   = 1'b0;
            writeNext = 1'b0;
            if (settleCnt == 2'd2) begin
               settleCntNext = '0;
               stateNext     = IDLE;
            end else begin
               settleCntNext = settleCnt + 2'd1;
            end
         end

         IDLE: begin
            if (ex_valid) begin
               if (isLoad) begin
                  selNext      = 1'b1;
                  writeNext    = 1'b0;
                  addrNext     = ex_addr;
                  loadRdNext   = ex_rd;
                  loadWbEnNext = ex_wb_en;
                  stateNext    = RD_ISSUE;
               end else if (isStore) begin
                  selNext       = 1'b1;
                  writeNext     = 1'b1;
                  addrNext      = ex_addr;
                  storeDataNext = ex_wdata;
                  stateNext     = WR;
               end else if (ex_wb_en) begin
                  wbValidNext = 1'b1;
                  wbRdNext    = ex_rd;
                  wbDataNext  = ex_alu;
               end
            end
         end

         WR: begin
            selNext   = 1'b0;
            writeNext = 1'b0;
            stateNext = IDLE;
         end

         RD_ISSUE: begin
            // mmu_ready still reflects the previous access here.
            stateNext = RD_WAIT;
         end

         RD_WAIT: begin
            if (mmu_ready) begin
               wbDataNext  = mmu_dat;
               wbRdNext    = loadRd;
               wbValidNext = loadWbEn;
               selNext     = 1'b0;
               stateNext   = DRAIN;
            end
         end

         DRAIN: begin
            // The mmu saw chipSel on the capture edge; wait out that read.
            if (mmu_ready) begin
               stateNext = IDLE;
            end
         end

         default: begin
            stateNext = SETTLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a behavioural mmu (write-around,
// read-allocate cache: hit = 1 cycle, miss = 2 cycles of ready low).
module tb_mem_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_load, ex_store, ex_wb_en;
   logic [4:0]  ex_rd;
   logic [7:0]  ex_addr;
   logic [31:0] ex_wdata, ex_alu;
   logic        stall, mmu_sel, mmu_write, mmu_ready;
   logic [7:0]  mmu_addr;
   wire  [31:0] mmu_dat;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          cyc;
   } rec_t;
   rec_t q[$];

   mem_stage_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
      .ex_wb_en(ex_wb_en), .ex_rd(ex_rd), .ex_addr(ex_addr),
      .ex_wdata(ex_wdata), .ex_alu(ex_alu),
      .stall(stall), .mmu_sel(mmu_sel), .mmu_addr(mmu_addr),
      .mmu_write(mmu_write), .mmu_dat(mmu_dat), .mmu_ready(mmu_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // mmu model: no reset, samples chipSel only while ready.
   logic [31:0]  mem [256];
   logic [255:0] cached = '0;
   logic [31:0]  mmuRdata = '0;
   logic [7:0]   rdAddr = '0;
   int           busy = 0;
   initial begin
      mmu_ready = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
   end

   assign mmu_dat = (mmu_sel && mmu_write) ? 32'bz : mmuRdata;

   always @(posedge clk) begin
      if (!mmu_ready) begin
         if (busy == 1) begin
            mmu_ready <= 1'b1;
            mmuRdata  <= mem[rdAddr];
            busy      <= 0;
         end else begin
            busy <= busy - 1;
         end
      end else if (mmu_sel) begin
         if (mmu_write) begin
            mem[mmu_addr] <= mmu_dat;
         end else begin
            mmu_ready        <= 1'b0;
            rdAddr           <= mmu_addr;
            busy             <= cached[mmu_addr] ? 1 : 2;
            cached[mmu_addr] <= 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every wb_valid pulse must match the oldest pending record.
   always @(negedge clk) begin : wbMon
      rec_t e;
      if (wb_valid === 1'b1) begin
         if (q.size() == 0) begin
            chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
         end else begin
            e = q.pop_front();
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
            chk("wb_data", wb_data, e.data);
            chk("wb_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic issue(input logic ld, input logic st, input logic wbEn,
                        input logic [4:0] rd, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [31:0] alu);
      ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_wb_en = wbEn;
      ex_rd = rd; ex_addr = addr; ex_wdata = wdata; ex_alu = alu;
      @(negedge clk);
      ex_valid = 1'b0;
   endtask

   task automatic waitIdle(input string tag, input int expCyc);
      int n = 0;
      while (stall !== 1'b0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk(tag, cyc, expCyc);
   endtask

   task automatic expectWb(input logic [4:0] rd, input logic [31:0] data, input int at);
      rec_t r;
      r.rd = rd; r.data = data; r.cyc = at;
      q.push_back(r);
   endtask

   initial begin
      int a;
      int r;
      rst_n = 1'b0;
      ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_wb_en = 1'b0;
      ex_rd = '0; ex_addr = '0; ex_wdata = '0; ex_alu = '0;
      repeat (3) @(negedge clk);

      chk("rst_stall", {31'd0, stall}, 32'd1);
      chk("rst_sel", {31'd0, mmu_sel}, 32'd0);
      chk("rst_write", {31'd0, mmu_write}, 32'd0);
      chk("rst_addr", {24'd0, mmu_addr}, 32'd0);
      chk("rst_wbvalid", {31'd0, wb_valid}, 32'd0);
      chk("rst_wbrd", {27'd0, wb_rd}, 32'd0);
      chk("rst_wbdata", wb_data, 32'd0);

      // Release: SETTLE holds for three edges.
      rst_n = 1'b1;
      r = cyc;
      @(negedge clk);
      chk("settle_stall1", {31'd0, stall}, 32'd1);
      chk("settle_sel1", {31'd0, mmu_sel}, 32'd0);
      @(negedge clk);
      chk("settle_stall2", {31'd0, stall}, 32'd1);
      chk("settle_sel2", {31'd0, mmu_sel}, 32'd0);
      @(negedge clk);
      chk("settle_stall3", {31'd0, stall}, 32'd0);
      chk("settle_cyc", cyc, r + 3);

      // Pass-through with write-back.
      a = cyc + 1;
      expectWb(5'd7, 32'h1234, a);
      issue(1'b0, 1'b0, 1'b1, 5'd7, 8'h00, 32'h0, 32'h1234);
      chk("pass_stall", {31'd0, stall}, 32'd0);
      // Pass-through without write-back is a no-op.
      issue(1'b0, 1'b0, 1'b0, 5'd8, 8'h00, 32'h0, 32'h5555);
      chk("nop_stall", {31'd0, stall}, 32'd0);

      // Store.
      issue(1'b0, 1'b1, 1'b1, 5'd2, 8'h10, 32'hDEADBEEF, 32'h0);
      chk("st_sel", {31'd0, mmu_sel}, 32'd1);
      chk("st_write", {31'd0, mmu_write}, 32'd1);
      chk("st_addr", {24'd0, mmu_addr}, 32'h10);
      chk("st_dat", mmu_dat, 32'hDEADBEEF);
      chk("st_stall", {31'd0, stall}, 32'd1);
      @(negedge clk);
      chk("st_sel_drop", {31'd0, mmu_sel}, 32'd0);
      chk("st_write_drop", {31'd0, mmu_write}, 32'd0);
      chk("st_idle", {31'd0, stall}, 32'd0);

      // Load miss; EX noise during the stall must be ignored.
      a = cyc + 1;
      expectWb(5'd5, 32'hDEADBEEF, a + 4);
      issue(1'b1, 1'b0, 1'b1, 5'd5, 8'h10, 32'h0, 32'h0);
      chk("ld_sel", {31'd0, mmu_sel}, 32'd1);
      chk("ld_write", {31'd0, mmu_write}, 32'd0);
      chk("ld_addr", {24'd0, mmu_addr}, 32'h10);
      ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0; ex_wb_en = 1'b1;
      ex_rd = 5'd3; ex_alu = 32'hBAD;
      waitIdle("miss_exit", a + 6);
      ex_valid = 1'b0;

      // Immediate reload, now a hit.
      a = cyc + 1;
      expectWb(5'd6, 32'hDEADBEEF, a + 3);
      issue(1'b1, 1'b0, 1'b1, 5'd6, 8'h10, 32'h0, 32'h0);
      waitIdle("hit_exit", a + 5);

      // Load without write-back runs the whole sequence silently.
      a = cyc + 1;
      issue(1'b1, 1'b0, 1'b0, 5'd11, 8'h10, 32'h0, 32'h0);
      waitIdle("nowb_exit", a + 5);

      // Both kind bits set behaves as a load.
      a = cyc + 1;
      expectWb(5'd9, 32'hDEADBEEF, a + 3);
      issue(1'b1, 1'b1, 1'b1, 5'd9, 8'h10, 32'h0, 32'h0);
      chk("both_write", {31'd0, mmu_write}, 32'd0);
      waitIdle("both_exit", a + 5);

      // Back-to-back stores every two cycles, then read both back.
      issue(1'b0, 1'b1, 1'b0, 5'd0, 8'h20, 32'hCAFEF00D, 32'h0);
      chk("st2a_write", {31'd0, mmu_write}, 32'd1);
      @(negedge clk);
      issue(1'b0, 1'b1, 1'b0, 5'd0, 8'h21, 32'h01234567, 32'h0);
      chk("st2b_write", {31'd0, mmu_write}, 32'd1);
      chk("st2b_dat", mmu_dat, 32'h01234567);
      @(negedge clk);
      a = cyc + 1;
      expectWb(5'd12, 32'hCAFEF00D, a + 4);
      issue(1'b1, 1'b0, 1'b1, 5'd12, 8'h20, 32'h0, 32'h0);
      waitIdle("ld20_exit", a + 6);
      a = cyc + 1;
      expectWb(5'd13, 32'h01234567, a + 4);
      issue(1'b1, 1'b0, 1'b1, 5'd13, 8'h21, 32'h0, 32'h0);
      waitIdle("ld21_exit", a + 6);

      // Reset during RD_WAIT of a miss.
      issue(1'b0, 1'b1, 1'b0, 5'd0, 8'h30, 32'hA5A55A5A, 32'h0);
      @(negedge clk);
      issue(1'b1, 1'b0, 1'b1, 5'd4, 8'h30, 32'h0, 32'h0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sel", {31'd0, mmu_sel}, 32'd0);
      chk("mid_rst_stall", {31'd0, stall}, 32'd1);
      chk("mid_rst_wbdata", wb_data, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      r = cyc;
      waitIdle("resettle_exit", r + 3);
      a = cyc + 1;
      expectWb(5'd14, 32'hA5A55A5A, a + 3);
      issue(1'b1, 1'b0, 1'b1, 5'd14, 8'h30, 32'h0, 32'h0);
      waitIdle("post_rst_exit", a + 5);

      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
